// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction/function codes, status,
// register ids and the condition-code bundle with its evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_INS = 3'd4
  } stat_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic cond_eval(
    input logic [3:0] fn,
    input cc_t        cc
  );
    logic lt;
    lt = cc.sf ^ cc.of;
    case (fn)
      C_YES:   return 1'b1;
      C_LE:    return lt | cc.zf;
      C_L:     return lt;
      C_E:     return cc.zf;
      C_NE:    return ~cc.zf;
      C_GE:    return ~lt;
      C_G:     return ~lt & ~cc.zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Y86-64 ALU: add / sub (b-a) / and / xor with ZF, SF, OF.
// Unknown function codes fall back to add.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   fn_i,
  output logic [W-1:0] result_o,
  output logic         zf_o,
  output logic         sf_o,
  output logic         of_o
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = b_i + a_i;
  assign diff = b_i - a_i;

  always_comb begin
    result_o = sum;
    of_o     = (a_i[W-1] == b_i[W-1]) &&
               (sum[W-1] != a_i[W-1]);
    case (fn_i)
      A_SUB: begin
        result_o = diff;
        of_o     = (a_i[W-1] != b_i[W-1]) &&
                   (diff[W-1] != b_i[W-1]);
      end
      A_AND: begin
        result_o = a_i & b_i;
        of_o     = 1'b0;
      end
      A_XOR: begin
        result_o = a_i ^ b_i;
        of_o     = 1'b0;
      end
      default: ;
    endcase
  end

  assign zf_o = (result_o == '0);
  assign sf_o = result_o[W-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand select, CC register, Cnd,
// sticky status FSM and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int W           = 64,
  parameter int STACK_DELTA = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         bubble,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valC,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [3:0]   rB,
  output logic         Cnd,
  output logic         m_valid,
  output logic [3:0]   m_icode,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic         m_Cnd,
  output logic [2:0]   stat
);

  localparam logic [W-1:0] DELTA = W'(STACK_DELTA);

  logic [W-1:0] alu_a, alu_b, val_e;
  logic [3:0]   alu_fn, dst_e;
  logic         alu_zf, alu_sf, alu_of;
  logic         cnd, aok, take, cc_we;
  cc_t          cc_q, cc_d;
  stat_e        stat_q, stat_d;

  logic         m_valid_q, m_cnd_q;
  logic [3:0]   m_icode_q, m_dst_q;
  logic [W-1:0] m_vale_q, m_vala_q;

  always_comb begin
    alu_a = '0;
    unique case (1'b1)
      (icode == I_RRMOVQ) || (icode == I_OPQ):
        alu_a = valA;
      (icode == I_IRMOVQ) || (icode == I_RMMOVQ) ||
      (icode == I_MRMOVQ):
        alu_a = valC;
      (icode == I_CALL) || (icode == I_PUSHQ):
        alu_a = '0 - DELTA;
      (icode == I_RET) || (icode == I_POPQ):
        alu_a = DELTA;
      default: ;
    endcase
  end

  always_comb begin
    alu_b = '0;
    if (icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
                      I_RET, I_PUSHQ, I_POPQ})
      alu_b = valB;
  end

  assign alu_fn = (icode == I_OPQ) ? ifun : A_ADD;

  y86_alu #(.W(W)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .fn_i     (alu_fn),
    .result_o (val_e),
    .zf_o     (alu_zf),
    .sf_o     (alu_sf),
    .of_o     (alu_of)
  );

  // Cnd sees the CC as it stood before this instruction
  assign cnd = ((icode == I_RRMOVQ) || (icode == I_JXX)) ?
               cond_eval(ifun, cc_q) : 1'b0;
  assign Cnd = cnd;

  always_comb begin
    dst_e = REG_NONE;
    unique case (1'b1)
      (icode == I_IRMOVQ) || (icode == I_OPQ):
        dst_e = rB;
      (icode == I_RRMOVQ):
        dst_e = cnd ? rB : REG_NONE;
      icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}:
        dst_e = REG_RSP;
      default: ;
    endcase
  end

  assign aok   = (stat_q == STAT_AOK);
  assign take  = in_valid & ~stall;
  assign cc_we = take & aok & (icode == I_OPQ) &
                 (ifun <= A_XOR);

  always_comb begin
    cc_d = cc_q;
    if (cc_we)
      cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
  end

  always_comb begin
    stat_d = stat_q;
    if (take && aok) begin
      if (icode == I_HALT)
        stat_d = STAT_HLT;
      else if ((icode > I_POPQ) ||
               ((icode == I_OPQ) && (ifun > A_XOR)))
        stat_d = STAT_INS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q   <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
      stat_q <= STAT_AOK;
    end else begin
      cc_q   <= cc_d;
      stat_q <= stat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_icode_q <= I_NOP;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dst_q   <= REG_NONE;
      m_cnd_q   <= 1'b0;
    end else if (!stall) begin
      if (bubble) begin
        m_valid_q <= 1'b0;
        m_icode_q <= I_NOP;
        m_dst_q   <= REG_NONE;
        m_cnd_q   <= 1'b0;
      end else begin
        m_valid_q <= in_valid & aok;
        m_icode_q <= in_valid ? icode : I_NOP;
        m_vale_q  <= val_e;
        m_vala_q  <= valA;
        m_dst_q   <= (in_valid && aok) ? dst_e : REG_NONE;
        m_cnd_q   <= cnd;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_icode = m_icode_q;
  assign m_valE  = m_vale_q;
  assign m_valA  = m_vala_q;
  assign m_dstE  = m_dst_q;
  assign m_Cnd   = m_cnd_q;
  assign stat    = stat_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed ISA scenarios plus randomized
// traffic checked against an instruction-level reference model.
module tb_execute_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         stall = 1'b0;
  logic         bubble = 1'b0;
  logic [3:0]   icode = 4'h1;
  logic [3:0]   ifun = 4'h0;
  logic [W-1:0] valC = '0;
  logic [W-1:0] valA = '0;
  logic [W-1:0] valB = '0;
  logic [3:0]   rB = 4'hF;
  logic         Cnd;
  logic         m_valid;
  logic [3:0]   m_icode;
  logic [W-1:0] m_valE;
  logic [W-1:0] m_valA;
  logic [3:0]   m_dstE;
  logic         m_Cnd;
  logic [2:0]   stat;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit           mz, ms, mo;
  int           mstat;
  logic         ev, ecnd;
  logic [3:0]   eic, edst;
  logic [W-1:0] eve, eva;
  bit           kv, kc;
  logic         cnd_obs, cnd_exp;

  execute_stage #(.W(W), .STACK_DELTA(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .stall    (stall),
    .bubble   (bubble),
    .icode    (icode),
    .ifun     (ifun),
    .valC     (valC),
    .valA     (valA),
    .valB     (valB),
    .rB       (rB),
    .Cnd      (Cnd),
    .m_valid  (m_valid),
    .m_icode  (m_icode),
    .m_valE   (m_valE),
    .m_valA   (m_valA),
    .m_dstE   (m_dstE),
    .m_Cnd    (m_Cnd),
    .stat     (stat)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mz = 1; ms = 0; mo = 0; mstat = 1;
    ev = 0; eic = 4'h1; eve = '0; eva = '0;
    edst = 4'hF; ecnd = 0; kv = 1; kc = 1;
  endtask

  function automatic bit mcond(input logic [3:0] f);
    case (f)
      4'h0: return 1;
      4'h1: return (ms != mo) || mz;
      4'h2: return ms != mo;
      4'h3: return mz;
      4'h4: return !mz;
      4'h5: return ms == mo;
      4'h6: return (ms == mo) && !mz;
      default: return 0;
    endcase
  endfunction

  // valE as the ISA defines it for each instruction
  function automatic logic [W-1:0] mvale(
    input logic [3:0] ic, input logic [3:0] fn,
    input logic [W-1:0] vc, input logic [W-1:0] va,
    input logic [W-1:0] vb);
    case (ic)
      4'h2: return va;
      4'h3: return vc;
      4'h4, 4'h5: return vb + vc;
      4'h6:
        case (fn)
          4'h0: return vb + va;
          4'h1: return vb - va;
          4'h2: return vb & va;
          4'h3: return vb ^ va;
          default: return '0;
        endcase
      4'h8, 4'hA: return vb - 64'd8;
      4'h9, 4'hB: return vb + 64'd8;
      default: return '0;
    endcase
  endfunction

  task automatic apply(
    input logic iv, input logic [3:0] ic, input logic [3:0] fn,
    input logic [W-1:0] vc, input logic [W-1:0] va,
    input logic [W-1:0] vb, input logic [3:0] rb,
    input logic st, input logic bb);
    logic [3:0] d;
    logic c;
    logic [W-1:0] r;
    logic signed [W:0] s;
    @(negedge clk);
    in_valid = iv; icode = ic; ifun = fn; valC = vc;
    valA = va; valB = vb; rB = rb; stall = st; bubble = bb;
    #1;
    cnd_obs = Cnd;
    c = (ic == 4'h2 || ic == 4'h7) ? mcond(fn) : 1'b0;
    cnd_exp = c;
    r = mvale(ic, fn, vc, va, vb);
    if (ic == 4'h3 || ic == 4'h6) d = rb;
    else if (ic == 4'h2) d = c ? rb : 4'hF;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) d = 4'h4;
    else d = 4'hF;
    if (!st) begin
      if (bb) begin
        ev = 0; eic = 4'h1; edst = 4'hF; ecnd = 0; kv = 0; kc = 1;
      end else begin
        ev = iv && (mstat == 1);
        eic = iv ? ic : 4'h1;
        eve = r; eva = va;
        edst = ev ? d : 4'hF;
        ecnd = c;
        kv = !(ic == 4'h6 && fn > 4'h3);
        kc = iv;
      end
      if (iv && ic == 4'h6 && mstat == 1 && fn <= 4'h3) begin
        mz = (r == '0);
        ms = r[W-1];
        if (fn == 4'h0) begin
          s = $signed({va[W-1], va}) + $signed({vb[W-1], vb});
          mo = s[W] != s[W-1];
        end else if (fn == 4'h1) begin
          s = $signed({vb[W-1], vb}) - $signed({va[W-1], va});
          mo = s[W] != s[W-1];
        end else mo = 0;
      end
      if (iv && mstat == 1) begin
        if (ic == 4'h0) mstat = 2;
        else if (ic > 4'hB || (ic == 4'h6 && fn > 4'h3)) mstat = 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    in_valid = 0; icode = 4'h7; ifun = 4'h3;
    #12;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", m_valid); end
    checks++; if (m_icode !== 4'h1) begin errors++; $display("FAIL reset_icode: got %0h want 1", m_icode); end
    checks++; if (m_valE !== 64'h0) begin errors++; $display("FAIL reset_valE: got %0h want 0", m_valE); end
    checks++; if (m_valA !== 64'h0) begin errors++; $display("FAIL reset_valA: got %0h want 0", m_valA); end
    checks++; if (m_dstE !== 4'hF) begin errors++; $display("FAIL reset_dstE: got %0h want f", m_dstE); end
    checks++; if (m_Cnd !== 1'b0) begin errors++; $display("FAIL reset_mCnd: got %0h want 0", m_Cnd); end
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0h want 1", stat); end
    checks++; if (Cnd !== 1'b1) begin errors++; $display("FAIL reset_zf_je: got %0h want 1", Cnd); end
    ifun = 4'h2; #1;
    checks++; if (Cnd !== 1'b0) begin errors++; $display("FAIL reset_jl: got %0h want 0", Cnd); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_sub_je();
    apply(1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h3, 0, 0);
    checks++; if (m_valE !== 64'h0) begin errors++; $display("FAIL sub_valE: got %0h want 0", m_valE); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %0h want 1", m_valid); end
    checks++; if (m_dstE !== 4'h3) begin errors++; $display("FAIL sub_dstE: got %0h want 3", m_dstE); end
    checks++; if (m_icode !== 4'h6) begin errors++; $display("FAIL sub_icode: got %0h want 6", m_icode); end
    apply(1, 4'h7, 4'h3, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b1) begin errors++; $display("FAIL sub_je: got %0h want 1", cnd_obs); end
    checks++; if (m_Cnd !== 1'b1) begin errors++; $display("FAIL sub_mCnd: got %0h want 1", m_Cnd); end
    apply(1, 4'h7, 4'h2, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b0) begin errors++; $display("FAIL sub_jl: got %0h want 0", cnd_obs); end
  endtask

  task automatic test_add_of();
    apply(1, 4'h6, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF,
          64'h7FFF_FFFF_FFFF_FFFF, 4'h1, 0, 0);
    checks++; if (m_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL add_valE: got %0h want fffffffffffffffe", m_valE); end
    apply(1, 4'h7, 4'h2, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b0) begin errors++; $display("FAIL add_jl: got %0h want 0", cnd_obs); end
    apply(1, 4'h7, 4'h6, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b1) begin errors++; $display("FAIL add_jg: got %0h want 1", cnd_obs); end
    apply(1, 4'h7, 4'h3, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b0) begin errors++; $display("FAIL add_je: got %0h want 0", cnd_obs); end
  endtask

  task automatic test_push_pop();
    apply(1, 4'hA, 4'h0, 0, 64'h1234, 64'h100, 4'hF, 0, 0);
    checks++; if (m_valE !== 64'hF8) begin errors++; $display("FAIL push_valE: got %0h want f8", m_valE); end
    checks++; if (m_dstE !== 4'h4) begin errors++; $display("FAIL push_dstE: got %0h want 4", m_dstE); end
    checks++; if (m_valA !== 64'h1234) begin errors++; $display("FAIL push_valA: got %0h want 1234", m_valA); end
    apply(1, 4'hB, 4'h0, 0, 0, 64'h100, 4'hF, 0, 0);
    checks++; if (m_valE !== 64'h108) begin errors++; $display("FAIL pop_valE: got %0h want 108", m_valE); end
    checks++; if (m_dstE !== 4'h4) begin errors++; $display("FAIL pop_dstE: got %0h want 4", m_dstE); end
    apply(1, 4'h7, 4'h4, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b1) begin errors++; $display("FAIL pushpop_cc_jne: got %0h want 1", cnd_obs); end
  endtask

  task automatic test_cmovl();
    apply(1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h3, 0, 0);
    apply(1, 4'h2, 4'h2, 0, 64'h77, 0, 4'h6, 0, 0);
    checks++; if (cnd_obs !== 1'b0) begin errors++; $display("FAIL cmovl0_Cnd: got %0h want 0", cnd_obs); end
    checks++; if (m_dstE !== 4'hF) begin errors++; $display("FAIL cmovl0_dstE: got %0h want f", m_dstE); end
    apply(1, 4'h6, 4'h1, 0, 64'd5, 64'd3, 4'h3, 0, 0);
    apply(1, 4'h2, 4'h2, 0, 64'h77, 0, 4'h6, 0, 0);
    checks++; if (cnd_obs !== 1'b1) begin errors++; $display("FAIL cmovl1_Cnd: got %0h want 1", cnd_obs); end
    checks++; if (m_dstE !== 4'h6) begin errors++; $display("FAIL cmovl1_dstE: got %0h want 6", m_dstE); end
    checks++; if (m_valE !== 64'h77) begin errors++; $display("FAIL cmovl1_valE: got %0h want 77", m_valE); end
  endtask

  task automatic test_stall_bubble();
    apply(1, 4'h3, 4'h0, 64'h55, 0, 0, 4'h2, 0, 0);
    apply(1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h3, 1, 0);
    checks++; if (m_valE !== 64'h55) begin errors++; $display("FAIL stall_valE: got %0h want 55", m_valE); end
    checks++; if (m_icode !== 4'h3) begin errors++; $display("FAIL stall_icode: got %0h want 3", m_icode); end
    checks++; if (m_dstE !== 4'h2) begin errors++; $display("FAIL stall_dstE: got %0h want 2", m_dstE); end
    apply(1, 4'h7, 4'h2, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b1) begin errors++; $display("FAIL stall_cc_jl: got %0h want 1", cnd_obs); end
    apply(1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h3, 1, 1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stallbub_valid: got %0h want 1", m_valid); end
    checks++; if (m_icode !== 4'h7) begin errors++; $display("FAIL stallbub_icode: got %0h want 7", m_icode); end
    apply(0, 4'h1, 4'h0, 0, 0, 0, 4'hF, 0, 1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %0h want 0", m_valid); end
    checks++; if (m_icode !== 4'h1) begin errors++; $display("FAIL bubble_icode: got %0h want 1", m_icode); end
    checks++; if (m_dstE !== 4'hF) begin errors++; $display("FAIL bubble_dstE: got %0h want f", m_dstE); end
  endtask

  function automatic logic [W-1:0] rval(input logic [W-1:0] other);
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return W'($urandom_range(0, 16));
      2: return ($urandom % 2 == 0) ? 64'h7FFF_FFFF_FFFF_FFFF
                                    : 64'h8000_0000_0000_0000;
      default: return other;
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] ics [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                             4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    for (int n = 0; n < 400; n++) begin
      logic iv, st, bb;
      logic [3:0] ic, fn, rb;
      logic [W-1:0] va, vb, vc;
      ic = ics[$urandom_range(0, 11)];
      if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 8));
      else fn = 4'($urandom_range(0, 15));
      iv = ($urandom % 4) != 0;
      st = ($urandom % 6) == 0;
      bb = ($urandom % 5) == 0;
      if (bb) iv = 0;
      rb = 4'($urandom_range(0, 15));
      va = rval(64'h0);
      vb = rval(va);
      vc = {$urandom, $urandom};
      apply(iv, ic, fn, vc, va, vb, rb, st, bb);
      checks++; if (cnd_obs !== cnd_exp) begin errors++; $display("FAIL rnd_Cnd[%0d]: got %0h want %0h", n, cnd_obs, cnd_exp); end
      checks++; if (m_valid !== ev) begin errors++; $display("FAIL rnd_valid[%0d]: got %0h want %0h", n, m_valid, ev); end
      checks++; if (m_icode !== eic) begin errors++; $display("FAIL rnd_icode[%0d]: got %0h want %0h", n, m_icode, eic); end
      checks++; if (m_dstE !== edst) begin errors++; $display("FAIL rnd_dstE[%0d]: got %0h want %0h", n, m_dstE, edst); end
      checks++; if (stat !== 3'(mstat)) begin errors++; $display("FAIL rnd_stat[%0d]: got %0h want %0h", n, stat, mstat); end
      if (kv) begin
        checks++; if (m_valE !== eve) begin errors++; $display("FAIL rnd_valE[%0d]: got %0h want %0h", n, m_valE, eve); end
        checks++; if (m_valA !== eva) begin errors++; $display("FAIL rnd_valA[%0d]: got %0h want %0h", n, m_valA, eva); end
      end
      if (kc) begin
        checks++; if (m_Cnd !== ecnd) begin errors++; $display("FAIL rnd_mCnd[%0d]: got %0h want %0h", n, m_Cnd, ecnd); end
      end
    end
  endtask

  task automatic test_halt();
    apply(1, 4'h6, 4'h1, 0, 64'd9, 64'd9, 4'h3, 0, 0);
    apply(1, 4'h0, 4'h0, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL halt_valid: got %0h want 1", m_valid); end
    checks++; if (m_icode !== 4'h0) begin errors++; $display("FAIL halt_icode: got %0h want 0", m_icode); end
    checks++; if (stat !== 3'd2) begin errors++; $display("FAIL halt_stat: got %0h want 2", stat); end
    apply(1, 4'h6, 4'h0, 0, 64'd1, 64'd1, 4'h5, 0, 0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL halt_after_valid: got %0h want 0", m_valid); end
    checks++; if (m_dstE !== 4'hF) begin errors++; $display("FAIL halt_after_dstE: got %0h want f", m_dstE); end
    checks++; if (stat !== 3'd2) begin errors++; $display("FAIL halt_sticky: got %0h want 2", stat); end
    apply(1, 4'h7, 4'h3, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (cnd_obs !== 1'b1) begin errors++; $display("FAIL halt_cc_frozen: got %0h want 1", cnd_obs); end
    do_reset();
  endtask

  task automatic test_ins();
    apply(1, 4'hC, 4'h0, 0, 0, 0, 4'hF, 0, 0);
    checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_c_stat: got %0h want 4", stat); end
    apply(1, 4'h3, 4'h0, 64'h9, 0, 0, 4'h2, 0, 0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ins_after_valid: got %0h want 0", m_valid); end
    checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_sticky: got %0h want 4", stat); end
    do_reset();
    apply(1, 4'h6, 4'h5, 0, 64'd1, 64'd2, 4'h2, 0, 0);
    checks++; if (stat !== 3'd4) begin errors++; $display("FAIL ins_opq_stat: got %0h want 4", stat); end
    do_reset();
  endtask

  task automatic test_async_reset();
    apply(1, 4'h6, 4'h0, 0, 64'd1, 64'd1, 4'h3, 0, 0);
    apply(1, 4'hC, 4'h0, 0, 0, 0, 4'hF, 0, 0);
    @(negedge clk);
    in_valid = 0; icode = 4'h7; ifun = 4'h3;
    #2;
    rst_n = 0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0h want 0", m_valid); end
    checks++; if (m_icode !== 4'h1) begin errors++; $display("FAIL areset_icode: got %0h want 1", m_icode); end
    checks++; if (m_valE !== 64'h0) begin errors++; $display("FAIL areset_valE: got %0h want 0", m_valE); end
    checks++; if (m_dstE !== 4'hF) begin errors++; $display("FAIL areset_dstE: got %0h want f", m_dstE); end
    checks++; if (stat !== 3'd1) begin errors++; $display("FAIL areset_stat: got %0h want 1", stat); end
    checks++; if (Cnd !== 1'b1) begin errors++; $display("FAIL areset_cc_je: got %0h want 1", Cnd); end
    #1;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sub_je();
    test_add_of();
    test_push_pop();
    test_cmovl();
    test_stall_bubble();
    test_random();
    test_halt();
    test_ins();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
